// File: rtl/fp21_from_fixed.sv
// Signed fixed-point to unpacked, normalized FP21 {sign, exp, frac} converter with an explicit zero flag.
// Five registered stages: abs, leading-zero count, normalize, round, pack. No backpressure.
module fp21_from_fixed #(
    parameter int IN_W      = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    output logic            sign_out,
    output logic [5:0]      exp_out,
    output logic [14:0]     frac_out,
    output logic            zero_out
);
    localparam int STAGES = 4;
    localparam int EBASE  = IN_W - 1 - FRAC_BITS;

    function automatic logic [4:0] lzc16(input logic [15:0] v);
        lzc16 = 5'd16;
        for (int i = 0; i < 16; i++)
            if (v[i]) lzc16 = 5'(15 - i);
    endfunction

    logic [STAGES:0] vld_pipe;

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
    end

    assign out_valid = vld_pipe[STAGES];

    // Stage 1: magnitude, left-aligned to 32 bits so the LZC and shifter are width-independent.
    logic [IN_W-1:0] abs_data;
    logic            s1_sign, s1_zero;
    logic [31:0]     s1_mag;

    assign abs_data = in_data[IN_W-1] ? -in_data : in_data;

    always_ff @(posedge clk) begin
        s1_sign <= in_data[IN_W-1];
        s1_zero <= (in_data == '0);
        s1_mag  <= 32'(abs_data) << (32 - IN_W);
    end

    // Stage 2: leading-zero count from two 16-bit halves.
    logic [4:0]  lzc_hi, lzc_lo;
    logic        s2_sign, s2_zero;
    logic [31:0] s2_mag;
    logic [5:0]  s2_lzc;

    assign lzc_hi = lzc16(s1_mag[31:16]);
    assign lzc_lo = lzc16(s1_mag[15:0]);

    always_ff @(posedge clk) begin
        s2_sign <= s1_sign;
        s2_zero <= s1_zero;
        s2_mag  <= s1_mag;
        s2_lzc  <= (s1_mag[31:16] == '0) ? 6'd16 + {1'b0, lzc_lo} : {1'b0, lzc_hi};
    end

    // Stage 3: normalize; the alignment padding keeps bits below the input LSB at zero.
    logic [31:0] norm;
    logic        s3_sign, s3_zero, s3_guard, s3_sticky;
    logic [14:0] s3_m;
    logic [5:0]  s3_exp;

    assign norm = s2_mag << s2_lzc;

    always_ff @(posedge clk) begin
        s3_sign   <= s2_sign;
        s3_zero   <= s2_zero;
        s3_m      <= norm[31:17];
        s3_guard  <= norm[16];
        s3_sticky <= |norm[15:0];
        s3_exp    <= 6'(EBASE - int'(s2_lzc));
    end

    // Stage 4: round to nearest, ties to even.
    logic        round_up;
    logic        s4_sign, s4_zero;
    logic [15:0] s4_r;
    logic [5:0]  s4_exp;

    assign round_up = s3_guard & (s3_sticky | s3_m[0]);

    always_ff @(posedge clk) begin
        s4_sign <= s3_sign;
        s4_zero <= s3_zero;
        s4_r    <= {1'b0, s3_m} + {15'd0, round_up};
        s4_exp  <= s3_exp;
    end

    // Stage 5: renormalize on rounding carry; outputs only load for valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_out <= 1'b0;
            exp_out  <= '0;
            frac_out <= '0;
            zero_out <= 1'b0;
        end else if (vld_pipe[STAGES-1]) begin
            if (s4_zero) begin
                sign_out <= 1'b0;
                exp_out  <= 6'b100000;
                frac_out <= '0;
                zero_out <= 1'b1;
            end else if (s4_r[15]) begin
                sign_out <= s4_sign;
                exp_out  <= s4_exp + 6'd1;
                frac_out <= s4_r[15:1];
                zero_out <= 1'b0;
            end else begin
                sign_out <= s4_sign;
                exp_out  <= s4_exp;
                frac_out <= s4_r[14:0];
                zero_out <= 1'b0;
            end
        end
    end
endmodule
